mips_debug_ctrl: RTL and testbench
==================================

// Module: mips_debug_ctrl
// PURPOSE
//  Sequences the MIPS pipeline (TP4) from a host byte link (UART RX/TX byte interface).
//  Loads program words into instruction memory and runs the pipeline continuously or one
//  cycle per step. After each run or step, streams PC, cycle count and all 32 registers
//  back to the host. Sits between the UART byte engine and the TP4 load/enable inputs.
// PARAMETERS
//  ADDR_W     7             instruction memory address width; depth = 2**ADDR_W words
//  HALT_WORD  32'hFFFFFFFF  halt instruction; ends LOAD, and the pipeline flags it at WB
// PORTS
//  CLK         in   1       clock; all logic on posedge
//  RESET       in   1       synchronous, active-high
//  RX_VALID    in   1       one-cycle strobe; RX_DATA is valid
//  RX_DATA     in   8       host byte
//  TX_DATA     out  8       byte to host
//  TX_VALID    out  1       TX_DATA valid; held until TX_READY is seen high
//  TX_READY    in   1       TX engine accepts the byte this cycle when TX_VALID=1
//  INSTR_OUT   out  32      assembled program word
//  INSTR_WE    out  1       one-cycle write strobe to instruction memory
//  INSTR_ADDR  out  ADDR_W  word address for INSTR_WE
//  CPU_EN      out  1       pipeline clock enable
//  CPU_RESET   out  1       pipeline synchronous reset
//  CPU_HALTED  in   1       HALT_WORD has reached WB
//  PC_IN       in   32      current IF PC
//  DBG_ADDR    out  5       register file debug read address
//  DBG_DATA    in   32      register data; valid 1 cycle after DBG_ADDR changes
//  CYCLE_CNT   out  32      enabled pipeline cycles since the last CPU_RESET
//  BUSY        out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0 except CPU_RESET=1 for that cycle. Counters cleared.
//  Commands (IDLE only; other bytes ignored):
//    'L'=8'h4C -> LOAD, 'C'=8'h43 -> RUN, 'S'=8'h53 -> STEP, 'R'=8'h52 -> CPU_RESET 1 cyc,
//    'D'=8'h44 -> DUMP.
//  LOAD: on entry, CPU_RESET=1 for 1 cycle and INSTR_ADDR=0.
//    Bytes arrive MSB first; 4 bytes make one word.
//    On the 4th byte: INSTR_WE=1 for one cycle, INSTR_OUT=word; next cycle INSTR_ADDR++.
//    Return to IDLE after writing HALT_WORD, or after writing address 2**ADDR_W-1.
//    No address wrap; extra bytes are ignored in IDLE.
//  RUN: CPU_EN=1 every cycle until CPU_HALTED is sampled high.
//    Then CPU_EN=0 in the next cycle and the block enters DUMP.
//    If CPU_HALTED is already high on entry, go to DUMP with zero enabled cycles.
//  STEP: CPU_EN=1 for exactly one cycle, then DUMP. Ignores CPU_HALTED.
//  CYCLE_CNT: +1 on every cycle with CPU_EN=1; saturates at 32'hFFFFFFFF.
//    Cleared whenever CPU_RESET=1.
//  DUMP: 34 words, each sent as 4 bytes MSB first.
//    Order: word0=PC_IN, word1=CYCLE_CNT, words 2..33 = R0..R31.
//    Substates FETCH/SEND. FETCH drives DBG_ADDR=idx-2 and waits 1 cycle, then latches
//    DBG_DATA (words 0/1 latch PC_IN/CYCLE_CNT directly).
//    SEND: one byte per TX_READY handshake; TX_VALID and TX_DATA stay stable while waiting.
//    After byte 136 is accepted: TX_VALID=0, return to IDLE.
//  RX bytes received in RUN, STEP or DUMP are dropped (no queue).
//  RESET in any state aborts the operation. A partial TX byte is abandoned (TX_VALID=0).
//    A partial LOAD word is discarded.
//  RX_VALID and a TX handshake in the same cycle are independent; both are processed.
// STRUCTURE
//  mips_dbg_defs.vh: command byte constants, HALT_WORD, state encodings
//    (IDLE, LOAD, RUN, STEP, FETCH, SEND), DUMP_WORDS=34.
//  One sub-module: dbg_word_serializer. It takes a 32-bit load strobe, runs the 4-byte
//    MSB-first TX handshake, and returns a done pulse.
//  Top FSM, byte packer, address counter and cycle counter stay inline.
// TESTING
//  1 'L', then bytes 20 01 00 05, then FF FF FF FF -> INSTR_WE at addr 0 = 32'h20010005,
//    at addr 1 = 32'hFFFFFFFF; then IDLE, BUSY=0.
//  2 'C' with CPU_HALTED rising after 9 enabled cycles -> CPU_EN high exactly 9 cycles;
//    dump word1 = 32'h00000009; 136 bytes total.
//  3 'S' twice after 'R' -> CPU_EN high 1 cycle each; second dump word1 = 32'h00000002.
//  4 TX_READY low 50 cycles mid-dump -> TX_DATA/TX_VALID stable; no byte lost or repeated.
//    Register words match DBG_ADDR 0..31 order.
//  5 Load 2**ADDR_W words with no HALT_WORD -> last write at addr 2**ADDR_W-1, then IDLE.
//    The next 4 bytes cause no write.
//  6 RESET asserted during SEND of word 10 -> next cycle state=IDLE, TX_VALID=0,
//    CYCLE_CNT=0, CPU_RESET=1.

Source files
------------

// File: rtl/mips_debug_ctrl_pkg.sv
// mips_debug_ctrl_pkg: shared states, command bytes and dump constants for the debug controller
package mips_debug_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, STEP, FETCH, SEND} state_e;
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_RST = 8'h52;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFFFFFF;
  localparam int DUMP_WORDS = 34;
  localparam logic [5:0] LAST_IDX = 6'(DUMP_WORDS - 1);
endpackage

// File: rtl/mips_debug_ctrl_serializer.sv
// dbg_word_serializer: sends a loaded 32-bit word as 4 MSB-first bytes over a valid/ready link
//   load_i/word_i in, tx_ready_i in, tx_data_o/tx_valid_o out, done_o pulses on the last byte handshake
module dbg_word_serializer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        done_o
);
  logic [31:0] sh_q;
  logic [1:0] n_q;
  logic v_q;
  logic acc;
  assign acc = v_q && tx_ready_i;
  assign done_o = acc && n_q == 2'd3;
  assign tx_data_o = sh_q[31:24];
  assign tx_valid_o = v_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sh_q <= '0;
      n_q <= '0;
      v_q <= 1'b0;
    end else if (load_i) begin
      sh_q <= word_i;
      n_q <= '0;
      v_q <= 1'b1;
    end else if (acc) begin
      sh_q <= {sh_q[23:0], 8'h00};
      n_q <= n_q + 2'd1;
      v_q <= n_q != 2'd3;
    end
  end
endmodule

// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl: host-byte debug sequencer for the MIPS pipeline (load, run, step, reset, dump)
//   RX_VALID/RX_DATA host bytes in; TX_DATA/TX_VALID/TX_READY dump bytes out
//   INSTR_OUT/INSTR_WE/INSTR_ADDR program writes; CPU_EN/CPU_RESET/CPU_HALTED/PC_IN pipeline control
//   DBG_ADDR/DBG_DATA register readback; CYCLE_CNT enabled cycles; BUSY not idle
module mips_debug_ctrl
  import mips_debug_ctrl_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RX_VALID,
  input  logic [7:0]        RX_DATA,
  output logic [7:0]        TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic [31:0]       INSTR_OUT,
  output logic              INSTR_WE,
  output logic [ADDR_W-1:0] INSTR_ADDR,
  output logic              CPU_EN,
  output logic              CPU_RESET,
  input  logic              CPU_HALTED,
  input  logic [31:0]       PC_IN,
  output logic [4:0]        DBG_ADDR,
  input  logic [31:0]       DBG_DATA,
  output logic [31:0]       CYCLE_CNT,
  output logic              BUSY
);
  state_e state_q, state_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [23:0] acc_q, acc_d;
  logic [31:0] instr_q, instr_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic cpu_rst_q, cpu_rst_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0] idx_q, idx_d;
  logic wait_q, wait_d;
  logic ld, done;
  logic [31:0] ld_word, word;
  assign word = {acc_q, RX_DATA};
  always_comb begin
    state_d = state_q;
    bcnt_d = bcnt_q;
    acc_d = acc_q;
    instr_d = instr_q;
    we_d = 1'b0;
    addr_d = we_q && addr_q != '1 ? ADDR_W'(addr_q + 1) : addr_q;
    cpu_rst_d = 1'b0;
    idx_d = idx_q;
    wait_d = 1'b0;
    ld = 1'b0;
    ld_word = idx_q == 6'd0 ? PC_IN : idx_q == 6'd1 ? cnt_q : DBG_DATA;
    CPU_EN = state_q == STEP || (state_q == RUN && !CPU_HALTED);
    cnt_d = cpu_rst_q ? '0 : CPU_EN && cnt_q != '1 ? cnt_q + 32'd1 : cnt_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (RX_VALID) begin
          if (RX_DATA == CMD_LOAD) begin
            state_d = LOAD;
            cpu_rst_d = 1'b1;
            addr_d = '0;
            bcnt_d = '0;
          end else if (RX_DATA == CMD_RST) cpu_rst_d = 1'b1;
          else if (RX_DATA == CMD_RUN) state_d = RUN;
          else if (RX_DATA == CMD_STEP) state_d = STEP;
          else if (RX_DATA == CMD_DUMP) state_d = FETCH;
        end
      end
      LOAD: if (RX_VALID) begin
        acc_d = word[23:0];
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          we_d = 1'b1;
          instr_d = word;
          state_d = word == HALT_WORD || addr_q == '1 ? IDLE : LOAD;
        end
      end
      RUN: state_d = CPU_HALTED ? FETCH : RUN;
      STEP: state_d = FETCH;
      FETCH: begin
        // DBG_DATA lags DBG_ADDR by a cycle, so the word is latched on the second FETCH cycle
        wait_d = !wait_q;
        ld = wait_q;
        state_d = wait_q ? SEND : FETCH;
      end
      SEND: if (done) begin
        state_d = idx_q == LAST_IDX ? IDLE : FETCH;
        idx_d = idx_q + 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      bcnt_q <= '0;
      acc_q <= '0;
      instr_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      cpu_rst_q <= 1'b1;
      cnt_q <= '0;
      idx_q <= '0;
      wait_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      acc_q <= acc_d;
      instr_q <= instr_d;
      we_q <= we_d;
      addr_q <= addr_d;
      cpu_rst_q <= cpu_rst_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      wait_q <= wait_d;
    end
  end
  dbg_word_serializer u_ser (
    .CLK       (CLK),
    .RESET     (RESET),
    .load_i    (ld),
    .word_i    (ld_word),
    .tx_ready_i(TX_READY),
    .tx_data_o (TX_DATA),
    .tx_valid_o(TX_VALID),
    .done_o    (done)
  );
  assign DBG_ADDR = (state_q == FETCH || state_q == SEND) && idx_q >= 6'd2 ? 5'(idx_q - 6'd2) : '0;
  assign INSTR_OUT = instr_q;
  assign INSTR_WE = we_q;
  assign INSTR_ADDR = addr_q;
  assign CPU_RESET = cpu_rst_q;
  assign CYCLE_CNT = cnt_q;
  assign BUSY = state_q != IDLE;
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb_mips_debug_ctrl: directed-vector bench for mips_debug_ctrl
module tb_mips_debug_ctrl;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic RX_VALID = 1'b0;
  logic [7:0] RX_DATA = '0;
  logic [7:0] TX_DATA;
  logic TX_VALID;
  logic TX_READY = 1'b1;
  logic [31:0] INSTR_OUT;
  logic INSTR_WE;
  logic [6:0] INSTR_ADDR;
  logic CPU_EN;
  logic CPU_RESET;
  logic CPU_HALTED = 1'b0;
  logic [31:0] PC_IN = '0;
  logic [4:0] DBG_ADDR;
  logic [31:0] DBG_DATA = '0;
  logic [31:0] CYCLE_CNT;
  logic BUSY;
  int vec = 0, miss = 0;
  int halt_at = 1000, ec = 0, en_seen = 0, rst_seen = 0;
  logic [7:0] rxq[$];
  logic [6:0] waddr[$];
  logic [31:0] wdata[$];

  mips_debug_ctrl dut (
    .CLK(CLK), .RESET(RESET), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .INSTR_OUT(INSTR_OUT), .INSTR_WE(INSTR_WE), .INSTR_ADDR(INSTR_ADDR),
    .CPU_EN(CPU_EN), .CPU_RESET(CPU_RESET), .CPU_HALTED(CPU_HALTED), .PC_IN(PC_IN),
    .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA), .CYCLE_CNT(CYCLE_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] regval(input logic [4:0] a);
    return {8'hC0, 3'b000, a, 8'h5A, 3'b000, a};
  endfunction

  always @(posedge CLK) begin
    DBG_DATA <= regval(DBG_ADDR);
    if (CPU_RESET) begin
      ec <= 0;
      CPU_HALTED <= 1'b0;
    end else if (CPU_EN) begin
      ec <= ec + 1;
      if (ec + 1 >= halt_at) CPU_HALTED <= 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (TX_VALID && TX_READY) rxq.push_back(TX_DATA);
    if (INSTR_WE) begin
      waddr.push_back(INSTR_ADDR);
      wdata.push_back(INSTR_OUT);
    end
    if (CPU_EN) en_seen++;
    if (CPU_RESET) rst_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA = b;
    RX_VALID = 1'b1;
    @(posedge CLK);
    #1 RX_VALID = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (BUSY && n < budget) begin
      @(posedge CLK);
      #1 n++;
    end
    chk("idle_timeout", {31'd0, BUSY}, 32'd0);
  endtask

  task automatic clear_mon();
    rxq.delete();
    waddr.delete();
    wdata.delete();
    en_seen = 0;
    rst_seen = 0;
  endtask

  task automatic check_dump(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    logic [31:0] w, e;
    chk({tag, "_len"}, rxq.size(), 32'd136);
    if (rxq.size() >= 136)
      for (int i = 0; i < 34; i++) begin
        w = {rxq[4*i], rxq[4*i+1], rxq[4*i+2], rxq[4*i+3]};
        e = i == 0 ? pc : i == 1 ? cnt : regval(5'(i - 2));
        chk($sformatf("%s_w%0d", tag, i), w, e);
      end
    chk({tag, "_txv"}, {31'd0, TX_VALID}, 32'd0);
  endtask

  initial begin
    logic [7:0] d0;
    logic stable;
    int n;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, BUSY}, 0);
    chk("rst_txv", {31'd0, TX_VALID}, 0);
    chk("rst_we", {31'd0, INSTR_WE}, 0);
    chk("rst_en", {31'd0, CPU_EN}, 0);
    chk("rst_cnt", CYCLE_CNT, 0);
    chk("rst_cpurst", {31'd0, CPU_RESET}, 1);
    RESET = 1'b0;
    @(posedge CLK);
    #1 chk("rst_cpurst_drop", {31'd0, CPU_RESET}, 0);

    clear_mon();
    send_byte(8'h4C);
    send_word(32'h20010005);
    send_word(32'hFFFFFFFF);
    repeat (2) @(posedge CLK);
    #1 chk("ld_busy", {31'd0, BUSY}, 0);
    chk("ld_nwr", waddr.size(), 2);
    chk("ld_cpurst", rst_seen, 1);
    if (waddr.size() == 2) begin
      chk("ld_a0", {25'd0, waddr[0]}, 0);
      chk("ld_d0", wdata[0], 32'h20010005);
      chk("ld_a1", {25'd0, waddr[1]}, 1);
      chk("ld_d1", wdata[1], 32'hFFFFFFFF);
    end

    clear_mon();
    PC_IN = 32'h00400024;
    halt_at = 9;
    send_byte(8'h43);
    wait_idle(2000);
    chk("run_en", en_seen, 9);
    check_dump("run", 32'h00400024, 32'd9);

    clear_mon();
    halt_at = 1000;
    PC_IN = 32'h00400028;
    send_byte(8'h52);
    chk("r_cpurst", rst_seen, 1);
    send_byte(8'h53);
    wait_idle(2000);
    chk("s1_en", en_seen, 1);
    check_dump("s1", 32'h00400028, 32'd1);
    clear_mon();
    PC_IN = 32'h0040002C;
    send_byte(8'h53);
    wait_idle(2000);
    chk("s2_en", en_seen, 1);
    check_dump("s2", 32'h0040002C, 32'd2);

    clear_mon();
    PC_IN = 32'h12345678;
    send_byte(8'h44);
    repeat (20) @(posedge CLK);
    #1 n = 0;
    while (!TX_VALID && n < 20) begin
      @(posedge CLK);
      #1 n++;
    end
    chk("hold_txv", {31'd0, TX_VALID}, 1);
    TX_READY = 1'b0;
    d0 = TX_DATA;
    stable = 1'b1;
    repeat (50) begin
      @(posedge CLK);
      #1 if (TX_DATA !== d0 || TX_VALID !== 1'b1) stable = 1'b0;
    end
    chk("hold_stable", {31'd0, stable}, 1);
    TX_READY = 1'b1;
    wait_idle(2000);
    chk("hold_en", en_seen, 0);
    check_dump("hold", 32'h12345678, 32'd2);

    clear_mon();
    send_byte(8'h4C);
    for (int i = 0; i < 128; i++) send_word(32'h0A0B0000 | i);
    repeat (2) @(posedge CLK);
    #1 chk("full_busy", {31'd0, BUSY}, 0);
    chk("full_nwr", waddr.size(), 128);
    if (waddr.size() == 128) begin
      chk("full_a_first", {25'd0, waddr[0]}, 0);
      chk("full_a_last", {25'd0, waddr[127]}, 127);
      chk("full_d_last", wdata[127], 32'h0A0B007F);
    end
    send_word(32'h00010203);
    repeat (2) @(posedge CLK);
    #1 chk("full_extra_nwr", waddr.size(), 128);
    chk("full_extra_busy", {31'd0, BUSY}, 0);

    clear_mon();
    halt_at = 5;
    send_byte(8'h43);
    n = 0;
    while (rxq.size() < 41 && n < 2000) begin
      @(posedge CLK);
      #1 n++;
    end
    chk("abort_reach", {31'd0, rxq.size() >= 41}, 1);
    chk("abort_txv_pre", {31'd0, TX_VALID}, 1);
    chk("abort_cnt_pre", CYCLE_CNT, 5);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort_busy", {31'd0, BUSY}, 0);
    chk("abort_txv", {31'd0, TX_VALID}, 0);
    chk("abort_cnt", CYCLE_CNT, 0);
    chk("abort_cpurst", {31'd0, CPU_RESET}, 1);
    RESET = 1'b0;
    repeat (2) @(posedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
